// File: rtl/ip_sequencer_pkg.sv
// Shared encodings for the stack-CPU program-flow sequencer:
// flow commands, fault codes and the controller state type.
package ip_sequencer_pkg;

    localparam logic [3:0] SEQ_NEXT  = 4'd0;
    localparam logic [3:0] SEQ_GOTO  = 4'd1;
    localparam logic [3:0] SEQ_IF_EQ = 4'd2;
    localparam logic [3:0] SEQ_IF_GT = 4'd3;
    localparam logic [3:0] SEQ_IF_LT = 4'd4;
    localparam logic [3:0] SEQ_IF_GE = 4'd5;
    localparam logic [3:0] SEQ_IF_LE = 4'd6;
    localparam logic [3:0] SEQ_CALL  = 4'd7;
    localparam logic [3:0] SEQ_RET   = 4'd8;

    localparam logic [1:0] FAULT_NONE = 2'b00;
    localparam logic [1:0] FAULT_OVF  = 2'b01;
    localparam logic [1:0] FAULT_UNF  = 2'b10;
    localparam logic [1:0] FAULT_ILL  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EVAL,
        S_RD,
        S_FAULT
    } seq_state_t;

    typedef struct packed {
        logic eq;
        logic gt;
        logic lt;
    } cmp_flags_t;

endpackage

// File: rtl/ip_sequencer_ret_addr_stack.sv
// Return-address storage: synchronous write, registered read.
// Pointer bookkeeping lives in the sequencer.
module ret_addr_stack
    import ip_sequencer_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/ip_sequencer.sv
// Program-flow controller: owns ip, executes NEXT/GOTO/IF_x/CALL/RET
// over a valid/ready handshake with a private return-address stack.
module ip_sequencer
    import ip_sequencer_pkg::*;
#(
    parameter int IP_W     = 8,
    parameter int RS_DEPTH = 8,
    parameter int DW       = $clog2(RS_DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [3:0]      cmd_op,
    input  logic [IP_W-1:0] cmd_target,
    input  logic            cmp_eq,
    input  logic            cmp_gt,
    input  logic            cmp_lt,
    output logic [IP_W-1:0] ip,
    output logic            done,
    output logic            taken,
    output logic [DW-1:0]   rs_depth,
    output logic            fault,
    output logic [1:0]      fault_code
);

    localparam int AW = $clog2(RS_DEPTH);
    localparam logic [DW-1:0] RS_FULL = DW'(RS_DEPTH);

    seq_state_t      state_q, state_d;
    logic [IP_W-1:0] ip_q, ip_d, tgt_q, tgt_d;
    logic [DW-1:0]   depth_q, depth_d;
    logic [3:0]      op_q, op_d;
    cmp_flags_t      cmp_q, cmp_d;
    logic            fault_q, fault_d;
    logic [1:0]      code_q, code_d;
    logic            done_q, done_d;
    logic            taken_q, taken_d;

    logic            wr_en, rd_en, cond;
    logic [IP_W-1:0] ip_inc, rd_data;
    logic [AW-1:0]   wr_addr, rd_addr;

    assign ip_inc  = ip_q + IP_W'(1);
    assign wr_addr = depth_q[AW-1:0];
    // Low bits wrap correctly even when depth == RS_DEPTH.
    assign rd_addr = depth_q[AW-1:0] - AW'(1);

    always_comb begin
        cond = 1'b0;
        case (op_q)
            SEQ_IF_EQ: cond = cmp_q.eq;
            SEQ_IF_GT: cond = cmp_q.gt;
            SEQ_IF_LT: cond = cmp_q.lt;
            SEQ_IF_GE: cond = cmp_q.gt | cmp_q.eq;
            SEQ_IF_LE: cond = cmp_q.lt | cmp_q.eq;
            default:   cond = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        ip_d      = ip_q;
        depth_d   = depth_q;
        op_d      = op_q;
        tgt_d     = tgt_q;
        cmp_d     = cmp_q;
        fault_d   = fault_q;
        code_d    = code_q;
        done_d    = 1'b0;
        taken_d   = 1'b0;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        cmd_ready = 1'b0;
        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    tgt_d   = cmd_target;
                    cmp_d   = '{eq: cmp_eq, gt: cmp_gt, lt: cmp_lt};
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                case (op_q)
                    SEQ_NEXT: ip_d = ip_inc;
                    SEQ_GOTO: begin
                        ip_d    = tgt_q;
                        taken_d = 1'b1;
                    end
                    SEQ_IF_EQ, SEQ_IF_GT, SEQ_IF_LT,
                    SEQ_IF_GE, SEQ_IF_LE: begin
                        ip_d    = cond ? tgt_q : ip_inc;
                        taken_d = cond;
                    end
                    SEQ_CALL: begin
                        if (depth_q == RS_FULL) begin
                            code_d = FAULT_OVF;
                        end else begin
                            wr_en   = 1'b1;
                            depth_d = depth_q + DW'(1);
                            ip_d    = tgt_q;
                            taken_d = 1'b1;
                        end
                    end
                    SEQ_RET: begin
                        if (depth_q == '0) begin
                            code_d = FAULT_UNF;
                        end else begin
                            rd_en   = 1'b1;
                            depth_d = depth_q - DW'(1);
                            state_d = S_RD;
                            done_d  = 1'b0;
                        end
                    end
                    default: code_d = FAULT_ILL;
                endcase
                if (code_d != FAULT_NONE) begin
                    state_d = S_FAULT;
                    fault_d = 1'b1;
                    done_d  = 1'b0;
                    taken_d = 1'b0;
                end
            end
            S_RD: begin
                ip_d    = rd_data;
                done_d  = 1'b1;
                taken_d = 1'b1;
                state_d = S_IDLE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ip_q    <= '0;
            depth_q <= '0;
            op_q    <= SEQ_NEXT;
            tgt_q   <= '0;
            cmp_q   <= '0;
            fault_q <= 1'b0;
            code_q  <= FAULT_NONE;
            done_q  <= 1'b0;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ip_q    <= ip_d;
            depth_q <= depth_d;
            op_q    <= op_d;
            tgt_q   <= tgt_d;
            cmp_q   <= cmp_d;
            fault_q <= fault_d;
            code_q  <= code_d;
            done_q  <= done_d;
            taken_q <= taken_d;
        end
    end

    ret_addr_stack #(
        .DEPTH (RS_DEPTH),
        .W     (IP_W)
    ) u_ras (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (ip_inc),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign ip         = ip_q;
    assign rs_depth   = depth_q;
    assign fault      = fault_q;
    assign fault_code = code_q;
    assign done       = done_q;
    assign taken      = taken_q;

endmodule

// File: tb/tb_ip_sequencer.sv
// Directed bench for ip_sequencer: flow commands, stack,
// wraparound, faults and reset mid-command.
module tb_ip_sequencer;
    import ip_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [7:0] cmd_target;
    logic       cmp_eq, cmp_gt, cmp_lt;
    logic [7:0] ip;
    logic       done, taken;
    logic [3:0] rs_depth;
    logic       fault;
    logic [1:0] fault_code;

    int checks = 0;
    int errors = 0;

    ip_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_target (cmd_target),
        .cmp_eq     (cmp_eq),
        .cmp_gt     (cmp_gt),
        .cmp_lt     (cmp_lt),
        .ip         (ip),
        .done       (done),
        .taken      (taken),
        .rs_depth   (rs_depth),
        .fault      (fault),
        .fault_code (fault_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic offer(input logic [3:0] op, input logic [7:0] tgt,
                         input logic [2:0] f);
        cmd_valid  = 1'b1;
        cmd_op     = op;
        cmd_target = tgt;
        {cmp_eq, cmp_gt, cmp_lt} = f;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        {cmp_eq, cmp_gt, cmp_lt} = 3'b000;
    endtask

    // Latency counted in cycles: accept cycle = 0, done cycle = n.
    task automatic do_cmd(input string tag, input logic [3:0] op,
                          input logic [7:0] tgt, input logic [2:0] f,
                          input logic [7:0] e_ip, input logic e_tk,
                          input int e_lat);
        int n;
        check({tag, "_rdy"}, 32'(cmd_ready), 1);
        offer(op, tgt, f);
        n = 1;
        while (!done && n < 8) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_lat"}, n, e_lat);
        check({tag, "_ip"}, 32'(ip), 32'(e_ip));
        check({tag, "_tk"}, 32'(taken), 32'(e_tk));
        check({tag, "_rdydone"}, 32'(cmd_ready), 1);
    endtask

    task automatic do_fault(input string tag, input logic [3:0] op,
                            input logic [7:0] tgt, input logic [1:0] e_code,
                            input logic [7:0] e_ip, input logic [3:0] e_dep);
        offer(op, tgt, 3'b000);
        @(posedge clk);
        #1;
        check({tag, "_flt"}, 32'(fault), 1);
        check({tag, "_code"}, 32'(fault_code), 32'(e_code));
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_ip"}, 32'(ip), 32'(e_ip));
        check({tag, "_dep"}, 32'(rs_depth), 32'(e_dep));
        cmd_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check({tag, "_rdy"}, 32'(cmd_ready), 0);
        check({tag, "_hold"}, 32'(fault_code), 32'(e_code));
        check({tag, "_ip2"}, 32'(ip), 32'(e_ip));
    endtask

    task automatic check_clear(input string tag);
        check({tag, "_ip"}, 32'(ip), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_tk"}, 32'(taken), 0);
        check({tag, "_dep"}, 32'(rs_depth), 0);
        check({tag, "_flt"}, 32'(fault), 0);
        check({tag, "_code"}, 32'(fault_code), 0);
        check({tag, "_rdy"}, 32'(cmd_ready), 1);
    endtask

    initial begin
        cmd_valid  = 1'b0;
        cmd_op     = 4'd0;
        cmd_target = 8'd0;
        {cmp_eq, cmp_gt, cmp_lt} = 3'b000;
        do_reset();
        check_clear("rst");

        do_cmd("next1", SEQ_NEXT, 8'h99, 3'b000, 8'h01, 1'b0, 2);
        do_cmd("next2", SEQ_NEXT, 8'h99, 3'b000, 8'h02, 1'b0, 2);
        do_cmd("next3", SEQ_NEXT, 8'h99, 3'b000, 8'h03, 1'b0, 2);

        do_cmd("goto", SEQ_GOTO, 8'h40, 3'b000, 8'h40, 1'b1, 2);
        do_cmd("ifge", SEQ_IF_GE, 8'h10, 3'b100, 8'h10, 1'b1, 2);
        do_cmd("iflt", SEQ_IF_LT, 8'h20, 3'b010, 8'h11, 1'b0, 2);
        do_cmd("ifeq0", SEQ_IF_EQ, 8'h77, 3'b000, 8'h12, 1'b0, 2);
        do_cmd("ifgt", SEQ_IF_GT, 8'h66, 3'b001, 8'h13, 1'b0, 2);
        do_cmd("ifle", SEQ_IF_LE, 8'h05, 3'b001, 8'h05, 1'b1, 2);

        do_cmd("call1", SEQ_CALL, 8'h30, 3'b000, 8'h30, 1'b1, 2);
        check("call1_dep", 32'(rs_depth), 1);
        do_cmd("call2", SEQ_CALL, 8'h50, 3'b000, 8'h50, 1'b1, 2);
        check("call2_dep", 32'(rs_depth), 2);
        do_cmd("ret1", SEQ_RET, 8'h00, 3'b000, 8'h31, 1'b1, 3);
        check("ret1_dep", 32'(rs_depth), 1);
        do_cmd("ret2", SEQ_RET, 8'h00, 3'b000, 8'h06, 1'b1, 3);
        check("ret2_dep", 32'(rs_depth), 0);

        for (int i = 0; i < 8; i++) begin
            do_cmd("callN", SEQ_CALL, 8'h80 + 8'(i), 3'b000,
                   8'h80 + 8'(i), 1'b1, 2);
        end
        check("full_dep", 32'(rs_depth), 8);
        do_fault("ovf", SEQ_CALL, 8'h99, FAULT_OVF, 8'h87, 4'd8);

        do_reset();
        check_clear("rst2");
        do_fault("unf", SEQ_RET, 8'h00, FAULT_UNF, 8'h00, 4'd0);
        do_reset();
        do_fault("ill", 4'd12, 8'h42, FAULT_ILL, 8'h00, 4'd0);
        do_reset();
        check_clear("rst3");

        do_cmd("gotoff", SEQ_GOTO, 8'hFF, 3'b000, 8'hFF, 1'b1, 2);
        do_cmd("wrap", SEQ_NEXT, 8'h00, 3'b000, 8'h00, 1'b0, 2);
        check("wrap_flt", 32'(fault), 0);
        do_cmd("gotoff2", SEQ_GOTO, 8'hFF, 3'b000, 8'hFF, 1'b1, 2);
        do_cmd("callff", SEQ_CALL, 8'h20, 3'b000, 8'h20, 1'b1, 2);
        do_cmd("retff", SEQ_RET, 8'h00, 3'b000, 8'h00, 1'b1, 3);

        do_cmd("call3", SEQ_CALL, 8'h44, 3'b000, 8'h44, 1'b1, 2);
        offer(SEQ_RET, 8'h00, 3'b000);
        @(posedge clk);
        #1;
        check("inrd_done", 32'(done), 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("rstrd_ip", 32'(ip), 0);
        check("rstrd_done", 32'(done), 0);
        check("rstrd_dep", 32'(rs_depth), 0);
        @(posedge clk);
        #1;
        check("rstrd_after", 32'(done), 0);
        check("rstrd_rdy", 32'(cmd_ready), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running expected finished");
        $fatal(1);
    end

endmodule
